// File: rtl/miriscv_instr_mem_responder.sv
// ---------------------------------------------------------------------------
// miriscv_instr_mem_responder
//
// Instruction-memory responder for the miriscv fetch interface. It accepts one
// outstanding fetch (level request plus byte address) and returns one 32-bit
// word after WAIT_STATES extra cycles. The word comes from an internal
// word-addressed array, which a side load port can write at any time.
//
// Ports:
//   clk_i          clock
//   arstn_i        asynchronous active-low reset
//   instr_req_i    fetch request, level, held while waiting
//   instr_addr_i   fetch byte address, valid while instr_req_i=1
//   instr_rvalid_o one-cycle response strobe per completed request
//   instr_rdata_o  instruction word, qualified by instr_rvalid_o
//   instr_err_o    access error flag, qualified by instr_rvalid_o
//   load_we_i      array write enable (program load)
//   load_addr_i    load byte address, bits [1:0] ignored
//   load_wdata_i   load data
// ---------------------------------------------------------------------------
module miriscv_instr_mem_responder #(
   parameter int          XLEN        = 32,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ERR_INSTR   = 32'h0000_0000,
   parameter string       INIT_FILE   = ""
) (
   input  logic            clk_i,
   input  logic            arstn_i,
   input  logic            instr_req_i,
   input  logic [XLEN-1:0] instr_addr_i,
   output logic            instr_rvalid_o,
   output logic [31:0]     instr_rdata_o,
   output logic            instr_err_o,
   input  logic            load_we_i,
   input  logic [XLEN-1:0] load_addr_i,
   input  logic [31:0]     load_wdata_i
);

   localparam int            IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [XLEN:0] SPAN  = (XLEN+1)'(4 * DEPTH_WORDS);
   localparam logic [3:0]    WS    = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Byte offset from BASE_ADDR, one bit wider than the address so that an
   // address below the base shows up as a huge (top-bit-set) offset.
   function automatic logic [XLEN:0] word_offset(input logic [XLEN-1:0] a);
      return {1'b0, a} - {1'b0, BASE_ADDR};
   endfunction

   // Below-base offsets wrap to values >= SPAN, so one compare covers both ends.
   function automatic logic in_range(input logic [XLEN:0] off);
      return off < SPAN;
   endfunction

   logic [31:0] mem [DEPTH_WORDS];

   state_t          state, state_next;
   logic [3:0]      cnt, cnt_next;
   logic [XLEN-1:0] addr_q, addr_next;

   logic [XLEN:0]      cap_off, load_off;
   logic               cap_err, load_ok, collide;
   logic [IDX_W-1:0]   cap_idx, load_idx;
   logic [31:0]        cap_data;

   // Next-state logic. Abort has priority over completion, and an address
   // change restarts the wait from the full count.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      addr_next  = addr_q;
      case (state)
         IDLE: begin
            if (instr_req_i) begin
               addr_next = instr_addr_i;
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = WS;
               end
            end
         end
         WAIT: begin
            if (!instr_req_i) begin
               state_next = IDLE;
            end else if (instr_addr_i != addr_q) begin
               addr_next = instr_addr_i;
               if (WAIT_STATES == 0) begin
                  state_next = RESP;
               end else begin
                  cnt_next = WS;
               end
            end else begin
               cnt_next = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The capture uses the address being latched at this edge, which equals
   // the held address except on the IDLE->RESP / restart->RESP paths.
   always_comb begin
      cap_off  = word_offset(addr_next);
      cap_err  = (cap_off[1:0] != 2'b00) || !in_range(cap_off);
      cap_idx  = cap_off[IDX_W+1:2];
      load_off = word_offset(load_addr_i);
      load_ok  = in_range(load_off);
      load_idx = load_off[IDX_W+1:2];
      // Same-edge load to the captured word is forwarded (write-first).
      collide  = load_we_i && load_ok && (load_idx == cap_idx);
      cap_data = ERR_INSTR;
      if (!cap_err) begin
         cap_data = collide ? load_wdata_i : mem[cap_idx];
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state          <= IDLE;
         cnt            <= '0;
         addr_q         <= '0;
         instr_rvalid_o <= 1'b0;
         instr_rdata_o  <= '0;
         instr_err_o    <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         addr_q         <= addr_next;
         instr_rvalid_o <= (state_next == RESP);
         if (state_next == RESP) begin
            instr_rdata_o <= cap_data;
            instr_err_o   <= cap_err;
         end
      end
   end

   // Array contents survive reset; out-of-range loads are dropped.
   always_ff @(posedge clk_i) begin
      if (load_we_i && load_ok) begin
         mem[load_idx] <= load_wdata_i;
      end
   end

endmodule

// File: tb/tb_miriscv_instr_mem_responder.sv
module tb_miriscv_instr_mem_responder;

   localparam logic [31:0] ERR = 32'hBAD0_BAD0;

   logic        clk   = 1'b0;
   logic        arstn = 1'b1;
   logic        req    [4];
   logic [31:0] addr   [4];
   logic        rvalid [4];
   logic [31:0] rdata  [4];
   logic        err    [4];
   logic        we     [4];
   logic [31:0] laddr  [4];
   logic [31:0] lwdata [4];

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   miriscv_instr_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ERR_INSTR(ERR)) u_ws0 (
      .clk_i(clk), .arstn_i(arstn), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
      .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
      .load_we_i(we[0]), .load_addr_i(laddr[0]), .load_wdata_i(lwdata[0]));

   miriscv_instr_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ERR_INSTR(ERR)) u_ws3 (
      .clk_i(clk), .arstn_i(arstn), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
      .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
      .load_we_i(we[1]), .load_addr_i(laddr[1]), .load_wdata_i(lwdata[1]));

   miriscv_instr_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_STATES(2), .ERR_INSTR(ERR)) u_ws2 (
      .clk_i(clk), .arstn_i(arstn), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
      .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]),
      .load_we_i(we[2]), .load_addr_i(laddr[2]), .load_wdata_i(lwdata[2]));

   miriscv_instr_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(4), .ERR_INSTR(ERR)) u_ws4 (
      .clk_i(clk), .arstn_i(arstn), .instr_req_i(req[3]), .instr_addr_i(addr[3]),
      .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]), .instr_err_o(err[3]),
      .load_we_i(we[3]), .load_addr_i(laddr[3]), .load_wdata_i(lwdata[3]));

   typedef struct {
      int          k;
      logic [31:0] a;
      logic [31:0] d;
      logic        e;
   } vec_t;

   vec_t tab [14];

   function automatic int ws_of(input int k);
      case (k)
         0:       return 0;
         1:       return 3;
         2:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] base_of(input int k);
      return (k == 3) ? 32'h0000_1000 : 32'h0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // One complete fetch: raise req, count edges to rvalid, drop req in the
   // response cycle, then confirm the strobe lasts a single cycle.
   task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] d, input logic e);
      int n;
      req[k]  = 1'b1;
      addr[k] = a;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rvalid[k] && n < 40);
      chk($sformatf("latency k%0d a%h", k, a), n, ws_of(k) + 1);
      chk($sformatf("rdata k%0d a%h", k, a), rdata[k], d);
      chk($sformatf("err k%0d a%h", k, a), 32'(err[k]), 32'(e));
      req[k] = 1'b0;
      tick();
      chk($sformatf("rvalid_low k%0d a%h", k, a), 32'(rvalid[k]), 32'h0);
   endtask

   initial begin
      int n;
      tab[0]  = '{0, 32'h0000_0000, 32'h0000_0013, 1'b0};
      tab[1]  = '{0, 32'h0000_0004, 32'hC0DE_0001, 1'b0};
      tab[2]  = '{0, 32'h0000_0002, ERR,           1'b1};
      tab[3]  = '{0, 32'h0000_0100, ERR,           1'b1};
      tab[4]  = '{0, 32'h0000_00FC, 32'hC0DE_003F, 1'b0};
      tab[5]  = '{1, 32'h0000_0000, 32'hC0DE_0100, 1'b0};
      tab[6]  = '{1, 32'h0000_0004, 32'hC0DE_0101, 1'b0};
      tab[7]  = '{1, 32'h0000_0008, 32'hC0DE_0102, 1'b0};
      tab[8]  = '{2, 32'h0000_0040, 32'hC0DE_0210, 1'b0};
      tab[9]  = '{2, 32'h0000_0103, ERR,           1'b1};
      tab[10] = '{3, 32'h0000_1008, 32'hC0DE_0302, 1'b0};
      tab[11] = '{3, 32'h0000_0FFC, ERR,           1'b1};
      tab[12] = '{3, 32'h0000_10FC, 32'hC0DE_033F, 1'b0};
      tab[13] = '{3, 32'h0000_1100, ERR,           1'b1};

      for (int k = 0; k < 4; k++) begin
         req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; laddr[k] = '0; lwdata[k] = '0;
      end

      // Reset state
      #2 arstn = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_rvalid k%0d", k), 32'(rvalid[k]), 32'h0);
         chk($sformatf("reset_rdata k%0d", k), rdata[k], 32'h0);
         chk($sformatf("reset_err k%0d", k), 32'(err[k]), 32'h0);
      end
      arstn = 1'b1;
      tick();

      // Program load: word i of DUT k = C0DE_kkii, DUT0 word 0 = addi x0 (0x13)
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 4; k++) begin
            we[k]     = 1'b1;
            laddr[k]  = base_of(k) + 32'(4 * i);
            lwdata[k] = 32'hC0DE_0000 | 32'(k << 8) | 32'(i);
            if (k == 0 && i == 0) lwdata[k] = 32'h0000_0013;
         end
         tick();
      end
      for (int k = 0; k < 4; k++) we[k] = 1'b0;
      tick();

      // Table-driven fetches
      for (int t = 0; t < 14; t++) fetch(tab[t].k, tab[t].a, tab[t].d, tab[t].e);

      // Abort (WAIT_STATES=2): drop req at the edge where the count is 1
      req[2] = 1'b1; addr[2] = 32'h0000_0008;
      tick();
      tick();
      req[2] = 1'b0;
      tick();
      chk("abort_no_resp", 32'(rvalid[2]), 32'h0);
      req[2] = 1'b1; addr[2] = 32'h0000_0040;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rvalid[2] && n < 40);
      chk("abort_new_latency", n, 3);
      chk("abort_new_rdata", rdata[2], 32'hC0DE_0210);
      req[2] = 1'b0;
      tick();
      chk("abort_single_strobe", 32'(rvalid[2]), 32'h0);

      // Restart (WAIT_STATES=3): address change mid-wait reloads the count
      req[1] = 1'b1; addr[1] = 32'h0000_0000;
      tick();
      tick();
      addr[1] = 32'h0000_000C;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rvalid[1] && n < 40);
      chk("restart_latency", n, 4);
      chk("restart_rdata", rdata[1], 32'hC0DE_0103);
      req[1] = 1'b0;
      tick();

      // Collision (WAIT_STATES=0): load and capture of word 5 at one edge
      req[0] = 1'b1; addr[0] = 32'h0000_0014;
      we[0] = 1'b1; laddr[0] = 32'h0000_0014; lwdata[0] = 32'hDEAD_BEEF;
      tick();
      we[0] = 1'b0;
      chk("collide_rvalid", 32'(rvalid[0]), 32'h1);
      chk("collide_rdata", rdata[0], 32'hDEAD_BEEF);
      chk("collide_err", 32'(err[0]), 32'h0);
      req[0] = 1'b0;
      tick();
      chk("collide_single_strobe", 32'(rvalid[0]), 32'h0);

      // Out-of-range load dropped; load address low bits ignored
      we[0] = 1'b1; laddr[0] = 32'h0000_0114; lwdata[0] = 32'h1111_1111;
      tick();
      laddr[0] = 32'h0000_001A; lwdata[0] = 32'h600D_F00D;
      tick();
      we[0] = 1'b0;
      fetch(0, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0);
      fetch(0, 32'h0000_0018, 32'h600D_F00D, 1'b0);

      // Reset during WAIT (WAIT_STATES=4)
      req[3] = 1'b1; addr[3] = 32'h0000_1000;
      tick();
      tick();
      arstn = 1'b0;
      #1;
      chk("midrst_rvalid", 32'(rvalid[3]), 32'h0);
      chk("midrst_rdata", rdata[3], 32'h0);
      chk("midrst_err", 32'(err[3]), 32'h0);
      req[3] = 1'b0;
      tick();
      arstn = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rvalid[3]) n++;
      end
      chk("midrst_no_resp", n, 0);
      fetch(3, 32'h0000_1004, 32'hC0DE_0301, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
